// File: rtl/status_flag_unit.sv
// Processor status flags: masked ALU flag write, save/restore LIFO, branch condition evaluation.
// Flag vectors are packed {Z,N,C,V}; the stack is indexed by the registered depth.
module status_flag_unit #(
    parameter int DEPTH  = 4,
    parameter bit BYPASS = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         flag_we_i,
    input  logic [3:0]                   flag_mask_i,
    input  logic                         z_i,
    input  logic                         n_i,
    input  logic                         c_i,
    input  logic                         v_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         err_clr_i,
    input  logic [3:0]                   cond_i,
    output logic                         z_o,
    output logic                         n_o,
    output logic                         c_o,
    output logic                         v_o,
    output logic                         cond_true_o,
    output logic [$clog2(DEPTH+1)-1:0]   depth_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic                         stack_err_o
);

    localparam int DW = $clog2(DEPTH+1);
    localparam int AW = $clog2(DEPTH);

    logic [3:0]    flags_q, flags_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          err_q, err_d;
    logic          stack_we;
    logic [3:0]    stack_q [DEPTH];
    logic          full_q, empty_q;
    logic [AW-1:0] wr_idx, top_idx;

    function automatic logic cond_eval(input logic [3:0] f, input logic [3:0] cc);
        logic z, n, c, v, r;
        {z, n, c, v} = f;
        r = 1'b0;
        case (cc)
            4'h0: r = z;
            4'h1: r = !z;
            4'h2: r = c;
            4'h3: r = !c;
            4'h4: r = n;
            4'h5: r = !n;
            4'h6: r = v;
            4'h7: r = !v;
            4'h8: r = c & !z;
            4'h9: r = !c | z;
            4'hA: r = (n == v);
            4'hB: r = (n != v);
            4'hC: r = !z & (n == v);
            4'hD: r = z | (n != v);
            4'hE: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign full_q  = (depth_q == DW'(DEPTH));
    assign empty_q = (depth_q == '0);
    assign wr_idx  = AW'(depth_q);
    assign top_idx = AW'(depth_q - DW'(1));

    always_comb begin
        flags_d  = flags_q;
        depth_d  = depth_q;
        err_d    = err_q & ~err_clr_i;
        stack_we = 1'b0;
        if (flag_we_i)
            flags_d = (flags_q & ~flag_mask_i) | ({z_i, n_i, c_i, v_i} & flag_mask_i);
        if (push_i && !pop_i) begin
            if (full_q) begin
                err_d = 1'b1;
            end else begin
                stack_we = 1'b1;
                depth_d  = depth_q + DW'(1);
            end
        end
        // A successful pop overrides any same-cycle flag write.
        if (pop_i && !push_i) begin
            if (empty_q) begin
                err_d = 1'b1;
            end else begin
                flags_d = stack_q[top_idx];
                depth_d = depth_q - DW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            flags_q <= '0;
            depth_q <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            depth_q <= depth_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_n_i && stack_we)
            stack_q[wr_idx] <= flags_q;
    end

    assign {z_o, n_o, c_o, v_o} = flags_q;
    assign cond_true_o = cond_eval(BYPASS ? flags_d : flags_q, cond_i);
    assign depth_o     = depth_q;
    assign full_o      = full_q;
    assign empty_o     = empty_q;
    assign stack_err_o = err_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// Bench for status_flag_unit: directed vector table, hand sequences for bypass/reset, and
// random traffic against a queue-based reference model. Two instances (BYPASS=0 and 1) share inputs.
module tb_status_flag_unit;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, we, push, pop, clr;
    logic [3:0] mask, fin, cond;

    logic       a_z, a_n, a_c, a_v, a_cond, a_full, a_empty, a_err;
    logic [2:0] a_depth;
    logic       b_z, b_n, b_c, b_v, b_cond, b_full, b_empty, b_err;
    logic [2:0] b_depth;

    status_flag_unit #(.DEPTH(DEPTH), .BYPASS(1'b0)) u_reg (
        .clk_i(clk), .rst_n_i(rst_n), .flag_we_i(we), .flag_mask_i(mask),
        .z_i(fin[3]), .n_i(fin[2]), .c_i(fin[1]), .v_i(fin[0]),
        .push_i(push), .pop_i(pop), .err_clr_i(clr), .cond_i(cond),
        .z_o(a_z), .n_o(a_n), .c_o(a_c), .v_o(a_v), .cond_true_o(a_cond),
        .depth_o(a_depth), .full_o(a_full), .empty_o(a_empty), .stack_err_o(a_err));

    status_flag_unit #(.DEPTH(DEPTH), .BYPASS(1'b1)) u_byp (
        .clk_i(clk), .rst_n_i(rst_n), .flag_we_i(we), .flag_mask_i(mask),
        .z_i(fin[3]), .n_i(fin[2]), .c_i(fin[1]), .v_i(fin[0]),
        .push_i(push), .pop_i(pop), .err_clr_i(clr), .cond_i(cond),
        .z_o(b_z), .n_o(b_n), .c_o(b_c), .v_o(b_v), .cond_true_o(b_cond),
        .depth_o(b_depth), .full_o(b_full), .empty_o(b_empty), .stack_err_o(b_err));

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: flags as a 4-bit value, stack as a queue.
    logic [3:0] m_flags;
    logic [3:0] m_stack[$];
    bit         m_err;
    bit         m_valid = 0;

    // Odd codes negate the even code below them; 0xE/0xF are always/never.
    function automatic logic model_cond(input logic [3:0] f, input logic [3:0] c);
        logic z, n, cy, v, base;
        {z, n, cy, v} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = n;
            3'd3: base = v;
            3'd4: base = cy && !z;
            3'd5: base = (n == v);
            3'd6: base = !z && (n == v);
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    task automatic tick();
        logic [3:0] nf;
        bit ne;
        int op;
        logic [9:0] exp_state;
        #2;
        op = 0;
        if (!rst_n) begin
            nf = 4'h0;
            ne = 0;
        end else begin
            nf = we ? ((m_flags & ~mask) | (fin & mask)) : m_flags;
            ne = m_err && !clr;
            if (push && !pop) begin
                if (m_stack.size() == DEPTH) ne = 1; else op = 1;
            end
            if (pop && !push) begin
                if (m_stack.size() == 0) ne = 1;
                else begin nf = m_stack[$]; op = 2; end
            end
        end
        if (m_valid) chk("cond_reg", 32'(a_cond), 32'(model_cond(m_flags, cond)));
        if (m_valid && rst_n) chk("cond_byp", 32'(b_cond), 32'(model_cond(nf, cond)));
        @(posedge clk);
        #1;
        if (!rst_n) m_stack.delete();
        else if (op == 1) m_stack.push_back(m_flags);
        else if (op == 2) void'(m_stack.pop_back());
        m_flags = nf;
        m_err   = ne;
        m_valid = 1;
        exp_state = {nf, 3'(m_stack.size()), m_stack.size() == DEPTH, m_stack.size() == 0, ne};
        chk("state_reg", 32'({a_z, a_n, a_c, a_v, a_depth, a_full, a_empty, a_err}), 32'(exp_state));
        chk("state_byp", 32'({b_z, b_n, b_c, b_v, b_depth, b_full, b_empty, b_err}), 32'(exp_state));
    endtask

    typedef struct {
        logic       rst_n, we;
        logic [3:0] mask, fin;
        logic       push, pop, clr;
        logic [3:0] cond;
        logic       chk_c, exp_c;
        logic [3:0] exp_f;
        logic [2:0] exp_d;
        logic       exp_e;
    } vec_t;

    function automatic vec_t mk(logic r, logic w, logic [3:0] m, logic [3:0] f, logic pu, logic po,
                                logic cl, logic [3:0] cd, logic cc, logic ec, logic [3:0] ef,
                                logic [2:0] ed, logic ee);
        vec_t t;
        t.rst_n = r; t.we = w; t.mask = m; t.fin = f; t.push = pu; t.pop = po; t.clr = cl;
        t.cond = cd; t.chk_c = cc; t.exp_c = ec; t.exp_f = ef; t.exp_d = ed; t.exp_e = ee;
        return t;
    endfunction

    vec_t vecs[$];

    initial begin
        rst_n = 0; we = 0; push = 0; pop = 0; clr = 0; mask = 0; fin = 0; cond = 0;
        //                 rst we mask   in     pu po cl cond  chk exp flags  d  err
        vecs.push_back(mk(0, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0, 0));
        vecs.push_back(mk(1, 1, 4'hF, 4'h8, 0, 0, 0, 4'h0, 1, 0, 4'h8, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h0, 1, 1, 4'h8, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h1, 1, 0, 4'h8, 0, 0));
        vecs.push_back(mk(1, 1, 4'hF, 4'h0, 0, 0, 0, 4'hE, 1, 1, 4'h0, 0, 0));
        vecs.push_back(mk(1, 1, 4'h4, 4'hF, 0, 0, 0, 4'hF, 1, 0, 4'h4, 0, 0));
        vecs.push_back(mk(1, 1, 4'hF, 4'h3, 0, 0, 0, 4'h5, 1, 0, 4'h3, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 0, 4'h6, 1, 1, 4'h3, 1, 0));
        vecs.push_back(mk(1, 1, 4'hF, 4'h8, 0, 0, 0, 4'h2, 1, 1, 4'h8, 1, 0));
        vecs.push_back(mk(1, 1, 4'hF, 4'h0, 0, 1, 0, 4'h0, 1, 1, 4'h3, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'hA, 1, 0, 4'h3, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h9, 1, 0, 4'h3, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'hB, 1, 1, 4'h3, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 0, 4'h8, 1, 1, 4'h3, 1, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 0, 4'hC, 1, 0, 4'h3, 2, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 0, 4'hD, 1, 1, 4'h3, 3, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 0, 4'h3, 1, 0, 4'h3, 4, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 0, 4'h0, 1, 0, 4'h3, 4, 1));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 0, 0, 4'h3, 4, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 0, 1, 4'h0, 0, 0, 4'h3, 4, 1));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 1, 4'h0, 0, 0, 4'h3, 4, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 1, 0, 4'hE, 1, 1, 4'h3, 3, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 1, 0, 4'hE, 1, 1, 4'h3, 2, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 1, 0, 4'hE, 1, 1, 4'h3, 1, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 1, 0, 4'hE, 1, 1, 4'h3, 0, 0));
        vecs.push_back(mk(1, 1, 4'hF, 4'h6, 0, 1, 0, 4'hF, 1, 0, 4'h6, 0, 1));
        vecs.push_back(mk(1, 1, 4'hF, 4'h9, 1, 1, 1, 4'h7, 1, 1, 4'h9, 0, 0));
        vecs.push_back(mk(1, 0, 4'h0, 4'h0, 0, 0, 0, 4'h4, 1, 0, 4'h9, 0, 0));

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            rst_n = vecs[i].rst_n; we = vecs[i].we; mask = vecs[i].mask; fin = vecs[i].fin;
            push = vecs[i].push; pop = vecs[i].pop; clr = vecs[i].clr; cond = vecs[i].cond;
            #1;
            if (vecs[i].chk_c) chk($sformatf("tbl%0d_cond", i), 32'(a_cond), 32'(vecs[i].exp_c));
            tick();
            chk($sformatf("tbl%0d_state", i), 32'({a_z, a_n, a_c, a_v, a_depth, a_err}),
                32'({vecs[i].exp_f, vecs[i].exp_d, vecs[i].exp_e}));
        end

        // Bypass: same-cycle visibility of a flag write on the BYPASS=1 instance only.
        we = 1; mask = 4'hF; fin = 4'h0; push = 0; pop = 0; clr = 0; cond = 4'h0;
        tick();
        fin = 4'h8;
        #1;
        chk("byp_same_cycle", 32'(b_cond), 32'd1);
        chk("reg_same_cycle", 32'(a_cond), 32'd0);
        tick();
        we = 0;
        #1;
        chk("reg_next_cycle", 32'(a_cond), 32'd1);
        tick();

        // Reset while the stack holds entries.
        push = 1; tick(); tick();
        push = 0; rst_n = 0; tick();
        chk("rst_mid_depth", 32'(a_depth), 32'd0);
        chk("rst_mid_flags", 32'({a_z, a_n, a_c, a_v}), 32'd0);
        rst_n = 1;

        for (int k = 0; k < 800; k++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            we    = $urandom_range(0, 1) == 1;
            mask  = 4'($urandom);
            fin   = 4'($urandom);
            push  = ($urandom_range(0, 2) == 0);
            pop   = ($urandom_range(0, 2) == 0);
            clr   = ($urandom_range(0, 7) == 0);
            cond  = 4'($urandom);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
